// File: rtl/adc_pkg.sv
// Shared types and default sizing for the ADC scan sequencer.
package adc_pkg;
  localparam int NCH_DEF = 8;
  localparam int DW_DEF  = 12;
  localparam int TMO_DEF = 255;

  typedef logic [2:0] ch_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT
  } state_e;
endpackage

// File: rtl/adc_chan_pick.sv
// Finds the lowest set mask bit above idx (or at idx when incl is high).
module adc_chan_pick
  import adc_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic [NCH-1:0] mask,
  input  ch_t            idx,
  input  logic           incl,
  output ch_t            nxt,
  output logic           none
);
  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(idx)) || (incl && (i == int'(idx))))) begin
        nxt  = ch_t'(i);
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/adc_scan_sequencer.sv
// Walks a latched channel mask, issuing one ADC conversion per set bit,
// banking results per channel and streaming them out with end-of-scan done.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           continuous,
  input  logic [NCH-1:0] chan_mask,
  output logic           cmd_valid,
  output logic [2:0]     cmd_channel,
  input  logic           cmd_ready,
  input  logic           rsp_valid,
  input  logic [2:0]     rsp_channel,
  input  logic [DW-1:0]  rsp_data,
  output logic           res_valid,
  output logic [2:0]     res_channel,
  output logic [DW-1:0]  res_data,
  input  logic [2:0]     rd_sel,
  output logic [DW-1:0]  rd_data,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  state_e                  state_q, state_d;
  logic [NCH-1:0]          scan_mask_q, scan_mask_d;
  ch_t                     cur_q, cur_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic                    res_valid_q, res_valid_d;
  ch_t                     res_channel_q, res_channel_d;
  logic [DW-1:0]           res_data_q, res_data_d;
  logic [NCH-1:0][DW-1:0]  bank_q, bank_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  ch_t  nxt_ch, first_ch;
  logic nxt_none, first_none;
  logic rsp_hit, tmo_hit;

  adc_chan_pick #(.NCH(NCH)) u_pick_next (
    .mask(scan_mask_q), .idx(cur_q), .incl(1'b0), .nxt(nxt_ch), .none(nxt_none)
  );

  adc_chan_pick #(.NCH(NCH)) u_pick_first (
    .mask(chan_mask), .idx(ch_t'(0)), .incl(1'b1), .nxt(first_ch), .none(first_none)
  );

  assign rsp_hit = rsp_valid && (rsp_channel == cur_q);
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    state_d       = state_q;
    scan_mask_d   = scan_mask_q;
    cur_d         = cur_q;
    tmo_d         = tmo_q;
    cmd_valid_d   = cmd_valid_q;
    res_valid_d   = 1'b0;
    res_channel_d = res_channel_q;
    res_data_d    = res_data_q;
    bank_d        = bank_q;
    done_d        = 1'b0;
    err_d         = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (first_none) begin
            done_d = 1'b1;
          end else begin
            scan_mask_d = chan_mask;
            cur_d       = first_ch;
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          tmo_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // done is raised here so it lines up with the registered result strobe.
        if (rsp_hit) begin
          bank_d[cur_q] = rsp_data;
          res_valid_d   = 1'b1;
          res_channel_d = cur_q;
          res_data_d    = rsp_data;
          done_d        = nxt_none;
          state_d       = ST_NEXT;
        end else begin
          if (rsp_valid) err_d = 1'b1;
          if (tmo_hit) begin
            err_d   = 1'b1;
            done_d  = nxt_none;
            state_d = ST_NEXT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      ST_NEXT: begin
        if (!nxt_none) begin
          cur_d       = nxt_ch;
          cmd_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end else if (continuous && !first_none) begin
          scan_mask_d = chan_mask;
          cur_d       = first_ch;
          cmd_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      scan_mask_q   <= '0;
      cur_q         <= '0;
      tmo_q         <= '0;
      cmd_valid_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_channel_q <= '0;
      res_data_q    <= '0;
      bank_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_mask_q   <= scan_mask_d;
      cur_q         <= cur_d;
      tmo_q         <= tmo_d;
      cmd_valid_q   <= cmd_valid_d;
      res_valid_q   <= res_valid_d;
      res_channel_q <= res_channel_d;
      res_data_q    <= res_data_d;
      bank_q        <= bank_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_channel = cur_q;
  assign res_valid   = res_valid_q;
  assign res_channel = res_channel_q;
  assign res_data    = res_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rd_data     = (int'(rd_sel) < NCH) ? bank_q[rd_sel] : '0;
endmodule
